// File: rtl/n101_qspi_flash_resp.sv
// SPI mode-0 flash responder for the n101 QSPI master: oversamples sck/cs/dq0 on clk
// and serves READ, PAGE PROGRAM, WRITE ENABLE and READ STATUS from an internal array.
module n101_qspi_flash_resp #(
    parameter int MEM_AW      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic io_port_sck,
    input  logic io_port_cs,
    input  logic io_port_dq_0_i,
    output logic io_port_dq_1_o,
    output logic io_port_dq_1_oe,
    output logic o_busy,
    output logic o_wel,
    output logic o_cmd_err
);
    localparam int MEM_SIZE = 1 << MEM_AW;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, dq0_sync;
    logic sck_s, cs_s, dq0_s, sck_d, cs_d;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [4:0] bit_cnt;
    logic [6:0] sh_in;
    logic [7:0] out_sh, wr_byte, cmd_byte, status_byte;
    logic [MEM_AW-1:0] ptr;
    logic is_read, wren_pend, prog_wel, load_pend, wr_pend, cmd_err;
    logic [7:0] mem [MEM_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            dq0_sync <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync[0] <= io_port_sck;
            cs_sync[0]  <= io_port_cs;
            dq0_sync[0] <= io_port_dq_0_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i] <= sck_sync[i-1];
                cs_sync[i]  <= cs_sync[i-1];
                dq0_sync[i] <= dq0_sync[i-1];
            end
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign dq0_s = dq0_sync[SYNC_STAGES-1];

    // sck edges only count while selected; a cs fall in the same clk takes priority
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = sck_s & ~sck_d & ~cs_s & ~cs_d;
    assign sck_fall = ~sck_s & sck_d & ~cs_s & ~cs_d;

    assign cmd_byte    = {sh_in, dq0_s};
    assign status_byte = {6'b0, o_wel, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cmd_err = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (cs_fall) begin
            state_d = CMD;
        end else if (sck_rise) begin
            case (state_q)
                CMD: begin
                    if (bit_cnt == 5'd7) begin
                        case (cmd_byte)
                            8'h03, 8'h02: state_d = ADDR;
                            8'h05:        state_d = STATUS;
                            8'h06:        state_d = IGNORE;
                            default: begin
                                state_d = IGNORE;
                                cmd_err = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (bit_cnt == 5'd23) state_d = is_read ? RD_DATA : WR_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            sh_in     <= '0;
            out_sh    <= '0;
            wr_byte   <= '0;
            ptr       <= '0;
            is_read   <= 1'b0;
            wren_pend <= 1'b0;
            prog_wel  <= 1'b0;
            load_pend <= 1'b0;
            wr_pend   <= 1'b0;
            o_wel     <= 1'b0;
            o_cmd_err <= 1'b0;
        end else begin
            o_cmd_err <= cmd_err;
            if (wr_pend) begin
                wr_pend <= 1'b0;
                ptr     <= ptr + 1'b1;
            end
            if (cs_rise) begin
                bit_cnt   <= '0;
                out_sh    <= '0;
                load_pend <= 1'b0;
                wren_pend <= 1'b0;
                prog_wel  <= 1'b0;
                if (wren_pend) o_wel <= 1'b1;
                if (prog_wel)  o_wel <= 1'b0;
            end else if (cs_fall) begin
                bit_cnt   <= '0;
                sh_in     <= '0;
                load_pend <= 1'b0;
                wren_pend <= 1'b0;
                prog_wel  <= 1'b0;
            end else begin
                if (sck_rise) begin
                    sh_in <= cmd_byte[6:0];
                    bit_cnt <= bit_cnt + 5'd1;
                    case (state_q)
                        CMD: begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                is_read   <= (cmd_byte == 8'h03);
                                wren_pend <= (cmd_byte == 8'h06);
                                prog_wel  <= (cmd_byte == 8'h02) & o_wel;
                                load_pend <= (cmd_byte == 8'h05);
                            end
                        end
                        ADDR: begin
                            ptr <= {ptr[MEM_AW-2:0], dq0_s};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt   <= '0;
                                load_pend <= is_read;
                            end
                        end
                        RD_DATA, STATUS: begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                load_pend <= 1'b1;
                                if (state_q == RD_DATA) ptr <= ptr + 1'b1;
                            end
                        end
                        WR_DATA: begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                wr_pend <= 1'b1;
                                wr_byte <= cmd_byte;
                            end
                        end
                        // any bit past the WREN opcode disqualifies it
                        IGNORE: wren_pend <= 1'b0;
                        default: ;
                    endcase
                end
                if (sck_fall && (state_q == RD_DATA || state_q == STATUS)) begin
                    if (load_pend) begin
                        out_sh    <= (state_q == STATUS) ? status_byte : mem[ptr];
                        load_pend <= 1'b0;
                    end else begin
                        out_sh <= {out_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
        end else if (wr_pend && prog_wel) begin
            mem[ptr] <= wr_byte;
        end
    end

    assign io_port_dq_1_oe = ~cs_s & (state_q == RD_DATA || state_q == STATUS);
    assign io_port_dq_1_o  = io_port_dq_1_oe & out_sh[7];
    assign o_busy          = ~cs_s;

endmodule

// File: tb/tb_n101_qspi_flash_resp.sv
// Bench for n101_qspi_flash_resp: a bit-banged SPI master drives transactions, a
// flash reference model queues expected read bytes, and a pin monitor checks them.
module tb_n101_qspi_flash_resp;
    localparam int HALF = 5;
    localparam int OP_READ = 0, OP_PROG = 1, OP_WREN = 2, OP_STATUS = 3, OP_RAW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic dq0 = 1'b0;
    logic dq1, oe, busy, wel, cmd_err;

    n101_qspi_flash_resp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_port_sck    (sck),
        .io_port_cs     (cs),
        .io_port_dq_0_i (dq0),
        .io_port_dq_1_o (dq1),
        .io_port_dq_1_oe(oe),
        .o_busy         (busy),
        .o_wel          (wel),
        .o_cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] ref_mem [256];
    logic ref_wel = 1'b0;
    int ref_err_pulses = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tx_data [8];
    int oe_cycles = 0;
    int err_cycles = 0;
    int err_pulses = 0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (oe) oe_cycles++;
        if (cmd_err) err_cycles++;
        if (cmd_err && !err_prev) err_pulses++;
        err_prev = cmd_err;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Pin-level monitor: assembles each byte the responder drives and checks it against the queue
    initial begin : monitor
        logic [7:0] mon_byte;
        int mon_cnt;
        mon_byte = '0;
        mon_cnt = 0;
        forever begin
            @(posedge sck or posedge cs or negedge rst_n);
            if (!rst_n || cs) begin
                mon_cnt = 0;
            end else if (oe) begin
                mon_byte = {mon_byte[6:0], dq1};
                mon_cnt++;
                if (mon_cnt == 8) begin
                    mon_cnt = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", mon_byte);
                    end else begin
                        checkOutput("dq1_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic sck_bit(input logic b);
        dq0 = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) sck_bit(v[7-i]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        dq0 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("oe_after_cs_rise", {31'h0, oe}, 32'h0);
        repeat (2 * HALF) @(negedge clk);
    endtask

    // One full transaction plus the matching reference-model update
    task automatic applyStimulus(input int op, input int addr, input int n, input int extra);
        logic [23:0] a;
        a = addr[23:0];
        cs_low();
        case (op)
            OP_READ: begin
                send_bits(8'h03, 8);
                checkOutput("busy_in_txn", {31'h0, busy}, 32'h1);
                checkOutput("oe_during_cmd", {31'h0, oe}, 32'h0);
                send_bits(a[23:16], 8);
                send_bits(a[15:8], 8);
                send_bits(a[7:0], 8);
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back(ref_mem[(addr + i) & 255]);
                    send_bits(8'($urandom), 8);
                end
            end
            OP_PROG: begin
                send_bits(8'h02, 8);
                send_bits(a[23:16], 8);
                send_bits(a[15:8], 8);
                send_bits(a[7:0], 8);
                for (int i = 0; i < n; i++) send_bits(tx_data[i], 8);
                send_bits(tx_data[n], extra);
                if (ref_wel)
                    for (int i = 0; i < n; i++) ref_mem[(addr + i) & 255] = tx_data[i];
                ref_wel = 1'b0;
            end
            OP_WREN: begin
                send_bits(8'h06, 8);
                send_bits(8'($urandom), extra);
                if (extra == 0) ref_wel = 1'b1;
            end
            OP_STATUS: begin
                send_bits(8'h05, 8);
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({6'b0, ref_wel, 1'b0});
                    send_bits(8'($urandom), 8);
                end
            end
            default: begin
                send_bits(tx_data[0], 8);
                for (int i = 0; i < n; i++) send_bits(8'($urandom), 8);
                ref_err_pulses++;
            end
        endcase
        cs_high();
    endtask

    initial begin : watchdog
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int op, addr, n, extra, oe0, err0, pul0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_wel", {31'h0, wel}, 32'h0);
        checkOutput("reset_oe", {31'h0, oe}, 32'h0);
        checkOutput("reset_dq1", {31'h0, dq1}, 32'h0);
        checkOutput("reset_cmd_err", {31'h0, cmd_err}, 32'h0);

        $display("[TB] read of erased memory");
        applyStimulus(OP_READ, 32'h10, 2, 0);

        $display("[TB] write enable, status, program with wrap");
        applyStimulus(OP_WREN, 0, 0, 0);
        checkOutput("wel_after_wren", {31'h0, wel}, 32'h1);
        applyStimulus(OP_STATUS, 0, 2, 0);
        tx_data[0] = 8'hA5; tx_data[1] = 8'h5A; tx_data[2] = 8'hC3;
        applyStimulus(OP_PROG, 32'hFE, 3, 0);
        checkOutput("wel_after_prog", {31'h0, wel}, 32'h0);
        applyStimulus(OP_STATUS, 0, 1, 0);
        applyStimulus(OP_READ, 32'hFE, 3, 0);

        $display("[TB] program without write enable");
        tx_data[0] = 8'h77;
        applyStimulus(OP_PROG, 32'h10, 1, 0);
        checkOutput("wel_no_wren", {31'h0, wel}, 32'h0);
        checkOutput("no_cmd_err", err_cycles, 32'h0);
        applyStimulus(OP_READ, 32'h10, 1, 0);

        $display("[TB] partial trailing byte");
        applyStimulus(OP_WREN, 0, 0, 0);
        tx_data[0] = 8'h11; tx_data[1] = 8'hEE;
        applyStimulus(OP_PROG, 32'h20, 1, 5);
        checkOutput("wel_after_partial", {31'h0, wel}, 32'h0);
        applyStimulus(OP_READ, 32'h20, 2, 0);

        $display("[TB] unsupported opcode and long WREN");
        oe0 = oe_cycles; err0 = err_cycles; pul0 = err_pulses;
        tx_data[0] = 8'h9F;
        applyStimulus(OP_RAW, 0, 1, 0);
        checkOutput("cmd_err_cycles", err_cycles - err0, 32'h1);
        checkOutput("cmd_err_pulses", err_pulses - pul0, 32'h1);
        checkOutput("oe_on_bad_cmd", oe_cycles - oe0, 32'h0);
        applyStimulus(OP_STATUS, 0, 1, 0);
        applyStimulus(OP_WREN, 0, 0, 1);
        checkOutput("wel_after_9bit_wren", {31'h0, wel}, 32'h0);

        $display("[TB] read from 0xFFFFFF wrapping");
        applyStimulus(OP_WREN, 0, 0, 0);
        tx_data[0] = 8'h12; tx_data[1] = 8'h34;
        applyStimulus(OP_PROG, 32'hFF, 2, 0);
        applyStimulus(OP_READ, 32'hFFFFFF, 3, 0);

        $display("[TB] randomized transactions");
        for (int k = 0; k < 24; k++) begin
            op = int'($urandom_range(0, 4));
            addr = int'($urandom_range(0, 32'hFFFFFF));
            n = int'($urandom_range(1, 4));
            extra = 0;
            for (int j = 0; j < 8; j++) tx_data[j] = 8'($urandom);
            if (op == OP_PROG) begin
                extra = int'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) applyStimulus(OP_WREN, 0, 0, 0);
            end else if (op == OP_WREN) begin
                if ($urandom_range(0, 3) == 0) extra = int'($urandom_range(1, 3));
            end else if (op == OP_RAW) begin
                if (tx_data[0] == 8'h02 || tx_data[0] == 8'h03 ||
                    tx_data[0] == 8'h05 || tx_data[0] == 8'h06) tx_data[0] = 8'h9F;
            end
            applyStimulus(op, addr, n, extra);
            checkOutput("wel_model", {31'h0, wel}, {31'h0, ref_wel});
        end

        applyStimulus(OP_READ, 0, 256, 0);
        checkOutput("cmd_err_total_cycles", err_cycles, ref_err_pulses);
        checkOutput("cmd_err_total_pulses", err_pulses, ref_err_pulses);

        $display("[TB] reset in the middle of a read");
        applyStimulus(OP_WREN, 0, 0, 0);
        checkOutput("wel_before_reset", {31'h0, wel}, 32'h1);
        cs_low();
        send_bits(8'h03, 8);
        send_bits(8'h00, 8);
        send_bits(8'h00, 8);
        send_bits(8'hFE, 8);
        send_bits(8'($urandom), 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("oe_in_reset", {31'h0, oe}, 32'h0);
        checkOutput("wel_in_reset", {31'h0, wel}, 32'h0);
        checkOutput("busy_in_reset", {31'h0, busy}, 32'h0);
        cs = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_wel = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(OP_READ, 32'hFE, 4, 0);
        applyStimulus(OP_STATUS, 0, 1, 0);

        checkOutput("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
